// File: rtl/fft_butterfly_feeder_if.sv
// Memory-side and butterfly-side bus of the FFT butterfly feeder.
// The feeder takes the master modport; RAM/ROM and the butterfly take the slave.
interface fft_butterfly_feeder_if #(
  parameter int N_LOG2 = 9,
  parameter int DATA_W = 16
);
  logic                     mem_rd_en;
  logic [N_LOG2-1:0]        mem_addr_a;
  logic [N_LOG2-1:0]        mem_addr_b;
  logic [N_LOG2-2:0]        tw_addr;
  logic signed [DATA_W-1:0] mem_a_real;
  logic signed [DATA_W-1:0] mem_a_imag;
  logic signed [DATA_W-1:0] mem_b_real;
  logic signed [DATA_W-1:0] mem_b_imag;
  logic signed [DATA_W-1:0] tw_real;
  logic signed [DATA_W-1:0] tw_imag;

  logic                     bf_iact;
  logic [1:0]               bf_ictrl;
  logic [N_LOG2-1:0]        bf_input_memory_address;
  logic signed [DATA_W-1:0] bf_A_real;
  logic signed [DATA_W-1:0] bf_A_imag;
  logic signed [DATA_W-1:0] bf_B_real;
  logic signed [DATA_W-1:0] bf_B_imag;
  logic signed [DATA_W-1:0] bf_twiddle_real;
  logic signed [DATA_W-1:0] bf_twiddle_imag;

  modport master (
    output mem_rd_en, mem_addr_a, mem_addr_b, tw_addr,
    input  mem_a_real, mem_a_imag, mem_b_real, mem_b_imag, tw_real, tw_imag,
    output bf_iact, bf_ictrl, bf_input_memory_address,
    output bf_A_real, bf_A_imag, bf_B_real, bf_B_imag, bf_twiddle_real, bf_twiddle_imag
  );

  modport slave (
    input  mem_rd_en, mem_addr_a, mem_addr_b, tw_addr,
    output mem_a_real, mem_a_imag, mem_b_real, mem_b_imag, tw_real, tw_imag,
    input  bf_iact, bf_ictrl, bf_input_memory_address,
    input  bf_A_real, bf_A_imag, bf_B_real, bf_B_imag, bf_twiddle_real, bf_twiddle_imag
  );
endinterface

// File: rtl/fft_butterfly_feeder.sv
// Walks the N/2 butterfly pairs of one FFT stage, reads operands from RAM/ROM
// and hands them, aligned and tagged, to the radix-2 butterfly.
module fft_butterfly_feeder #(
  parameter int N_LOG2 = 9,
  parameter int DATA_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] stage,
  input  logic       hold,
  output logic       busy,
  output logic       done,
  output logic       stage_err,
  fft_butterfly_feeder_if.master bus
);

  localparam int K_W = N_LOG2 - 1;
  localparam logic [K_W-1:0] K_LAST = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q;
  logic [3:0]        stage_q;
  logic              issue, accept, bad_start, last_out;

  logic [3:0]        ins_pos;
  logic [N_LOG2-1:0] k_ext, half, low_mask, addr_a, addr_b;
  logic [K_W-1:0]    tw_idx;

  logic              p1_valid;
  logic [1:0]        p1_ictrl;
  logic [N_LOG2-1:0] p1_addr;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    accept    = 1'b0;
    bad_start = 1'b0;
    last_out  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (int'(stage) < N_LOG2) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            bad_start = 1'b1;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          issue = 1'b1;
          if (k_q == K_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.bf_iact && bus.bf_ictrl[1]) begin
          last_out = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // addr_a is k with a zero spliced in at bit N_LOG2-1-s; addr_b sets that bit.
  always_comb begin
    ins_pos  = 4'(N_LOG2 - 1) - stage_q;
    k_ext    = {1'b0, k_q};
    half     = {{K_W{1'b0}}, 1'b1} << ins_pos;
    low_mask = half - N_LOG2'(1);
    addr_a   = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
    addr_b   = addr_a | half;
    tw_idx   = (k_q & low_mask[K_W-1:0]) << stage_q;
  end

  assign busy           = (state_q != IDLE);
  assign bus.mem_rd_en  = issue;
  assign bus.mem_addr_a = issue ? addr_a : '0;
  assign bus.mem_addr_b = issue ? addr_b : '0;
  assign bus.tw_addr    = issue ? tw_idx : '0;

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous to clk.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      k_q       <= '0;
      stage_q   <= '0;
      done      <= 1'b0;
      stage_err <= 1'b0;
    end else begin
      done      <= last_out;
      stage_err <= bad_start;
      if (accept) begin
        stage_q <= stage;
        k_q     <= '0;
      end else if (issue) begin
        k_q <= k_q + K_W'(1);
      end
    end
  end

  // Stage 1 tracks the pair tag while the RAM/ROM read is in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      p1_valid <= 1'b0;
      p1_ictrl <= '0;
      p1_addr  <= '0;
    end else begin
      p1_valid <= issue;
      if (issue) begin
        p1_ictrl <= {k_q == K_LAST, k_q == '0};
        p1_addr  <= addr_a;
      end
    end
  end

  // Stage 2 captures read data; outputs hold their last values between pairs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.bf_iact                 <= 1'b0;
      bus.bf_ictrl                <= '0;
      bus.bf_input_memory_address <= '0;
      bus.bf_A_real               <= '0;
      bus.bf_A_imag               <= '0;
      bus.bf_B_real               <= '0;
      bus.bf_B_imag               <= '0;
      bus.bf_twiddle_real         <= '0;
      bus.bf_twiddle_imag         <= '0;
    end else begin
      bus.bf_iact <= p1_valid;
      if (p1_valid) begin
        bus.bf_ictrl                <= p1_ictrl;
        bus.bf_input_memory_address <= p1_addr;
        bus.bf_A_real               <= bus.mem_a_real;
        bus.bf_A_imag               <= bus.mem_a_imag;
        bus.bf_B_real               <= bus.mem_b_real;
        bus.bf_B_imag               <= bus.mem_b_imag;
        bus.bf_twiddle_real         <= bus.tw_real;
        bus.bf_twiddle_imag         <= bus.tw_imag;
      end
    end
  end

endmodule
